instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/proc_pkg.sv | 24 ++
 rtl/instr_ram.sv | 25 ++
 rtl/instr_mem_loader.sv | 107 ++++++++++
 tb/tb_instr_mem_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode encodings, instruction memory depth
// and the program loader state encoding.
package proc_pkg;

  localparam int DEPTH = 32;

  // The opcode sits in the top two bits of each instruction byte.
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [7:0] NOP_INSTR = {OP_NOP, 6'b000000};

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/instr_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// The contents are deliberately not reset.
module instr_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_mem_loader.sv
// Downloads a framed program (length, bytes, XOR check) into instruction RAM
// and holds the processor in reset until a verified program is resident.
module instr_mem_loader #(
  parameter int DEPTH = proc_pkg::DEPTH,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   prog_len
);

  import proc_pkg::*;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  loader_state_t state;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_next;
  logic [AW:0]   len_q;
  logic [7:0]    xor_q;
  logic [7:0]    ram_rd;
  logic          hs;
  logic          wr_en;

  assign in_ready = ((state == LEN) || (state == DATA) || (state == CHECK)) && !load_start;
  assign hs       = in_valid && in_ready;
  assign wr_en    = hs && (state == DATA);
  assign cnt_next = cnt + 1'b1;
  assign cpu_hold = ~load_done;

  // Anything outside the committed program fetches as a NOP.
  assign rd_data = (load_done && ({1'b0, rd_addr} < prog_len)) ? ram_rd : NOP_INSTR;

  // The counter never exceeds len_q-1 at a write, so entry DEPTH-1 is the last possible write.
  instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      xor_q     <= '0;
      prog_len  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (load_start) begin
      state     <= LEN;
      cnt       <= '0;
      xor_q     <= '0;
      prog_len  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (hs) begin
      case (state)
        LEN: begin
          xor_q <= in_data;
          len_q <= in_data[AW:0];
          if ((in_data == 8'h00) || (in_data > DEPTH_B)) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          xor_q <= xor_q ^ in_data;
          cnt   <= cnt_next;
          if (cnt_next == len_q) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (in_data == xor_q) begin
            state     <= DONE;
            prog_len  <= len_q;
            load_done <= 1'b1;
          end else begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader: good, bad and full
// downloads, restart, reset mid-frame and back-pressure.
module tb_instr_mem_loader;

  logic       clk;
  logic       reset;
  logic       load_start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [5:0] prog_len;

  int checks;
  int failures;

  instr_mem_loader #(
    .DEPTH (32),
    .AW    (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .prog_len   (prog_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Optional idle cycles with garbage data precede each valid byte.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hFF;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  task automatic startLoad();
    @(negedge clk);
    load_start = 1'b1;
    #1;
    checkOutput("ready_low_on_start", 32'(in_ready), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    #1;
    checkOutput("ready_in_len", 32'(in_ready), 32'd1);
  endtask

  task automatic sendSmallFrame(input logic [7:0] chk, input int gap);
    applyStimulus(8'h03, gap);
    applyStimulus(8'h05, gap);
    applyStimulus(8'h1A, gap);
    applyStimulus(8'h61, gap);
    applyStimulus(chk, gap);
  endtask

  task automatic checkReadAt(input string tag, input logic [4:0] a, input logic [7:0] exp_val);
    rd_addr = a;
    #1;
    checkOutput(tag, 32'(rd_data), 32'(exp_val));
  endtask

  task automatic checkGoodProgram(input string pfx);
    checkOutput({pfx, "_done"},   32'(load_done), 32'd1);
    checkOutput({pfx, "_err"},    32'(load_err),  32'd0);
    checkOutput({pfx, "_hold"},   32'(cpu_hold),  32'd0);
    checkOutput({pfx, "_len"},    32'(prog_len),  32'd3);
    checkOutput({pfx, "_ready"},  32'(in_ready),  32'd0);
    checkReadAt({pfx, "_rd0"}, 5'd0, 8'h05);
    checkReadAt({pfx, "_rd1"}, 5'd1, 8'h1A);
    checkReadAt({pfx, "_rd2"}, 5'd2, 8'h61);
    checkReadAt({pfx, "_rd3"}, 5'd3, 8'hC0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    rd_addr    = 5'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(in_ready),  32'd0);
    checkOutput("rst_done",  32'(load_done), 32'd0);
    checkOutput("rst_err",   32'(load_err),  32'd0);
    checkOutput("rst_hold",  32'(cpu_hold),  32'd1);
    checkOutput("rst_len",   32'(prog_len),  32'd0);
    checkReadAt("rst_rd", 5'd0, 8'hC0);
    reset = 1'b0;

    // IDLE ignores in_valid until load_start arrives
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h03;
    repeat (2) @(negedge clk);
    checkOutput("idle_ready", 32'(in_ready), 32'd0);
    checkOutput("idle_err",   32'(load_err), 32'd0);
    in_valid = 1'b0;

    $display("[TB] good load");
    startLoad();
    sendSmallFrame(8'h7D, 0);
    checkGoodProgram("good");

    $display("[TB] bad checksum");
    startLoad();
    sendSmallFrame(8'h7C, 0);
    checkOutput("badck_err",  32'(load_err),  32'd1);
    checkOutput("badck_done", 32'(load_done), 32'd0);
    checkOutput("badck_len",  32'(prog_len),  32'd0);
    checkOutput("badck_hold", 32'(cpu_hold),  32'd1);
    for (int a = 0; a < 32; a++) begin
      checkReadAt($sformatf("badck_rd%0d", a), 5'(a), 8'hC0);
    end

    $display("[TB] bad lengths");
    startLoad();
    applyStimulus(8'h00, 0);
    checkOutput("len00_err",   32'(load_err), 32'd1);
    checkOutput("len00_ready", 32'(in_ready), 32'd0);
    startLoad();
    applyStimulus(8'h21, 0);
    checkOutput("len21_err",   32'(load_err), 32'd1);
    checkOutput("len21_ready", 32'(in_ready), 32'd0);
    checkOutput("len21_len",   32'(prog_len), 32'd0);

    // Bytes 00..1F XOR to zero, so the check byte equals the length byte.
    $display("[TB] full load");
    startLoad();
    applyStimulus(8'h20, 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(8'(i), 0);
    end
    applyStimulus(8'h20, 0);
    checkOutput("full_done", 32'(load_done), 32'd1);
    checkOutput("full_len",  32'(prog_len),  32'd32);
    checkReadAt("full_rd1f", 5'h1F, 8'h1F);
    checkReadAt("full_rd00", 5'h00, 8'h00);
    checkReadAt("full_rd10", 5'h10, 8'h10);

    $display("[TB] restart");
    startLoad();
    applyStimulus(8'h03, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    startLoad();
    sendSmallFrame(8'h7D, 0);
    checkGoodProgram("restart");

    startLoad();
    applyStimulus(8'h03, 0);
    applyStimulus(8'h05, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_hold",  32'(cpu_hold),  32'd1);
    checkOutput("midrst_done",  32'(load_done), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready),  32'd0);
    checkOutput("midrst_len",   32'(prog_len),  32'd0);
    checkReadAt("midrst_rd", 5'd1, 8'hC0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h1A;
    repeat (2) @(negedge clk);
    checkOutput("postrst_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    $display("[TB] back-pressure");
    startLoad();
    sendSmallFrame(8'h7D, 1);
    checkGoodProgram("bp");

    $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
